// File: rtl/i2s_transmitter.sv
// Purpose: serialize the 16-bit mono NCO sample into a Philips I2S frame (same word in L and R slots).
// Latency: capture to first MSB on sdata is 1..2*SLOT_BITS BCLK periods (until next frame load) plus 1 BCLK.
// Backpressure: none; the strobe is never stalled, overrun/underrun pulses flag lost or repeated samples.
//
// Ports:
//   master_clk     in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   sample_clk_en  in   48 kHz single-cycle strobe, captures sample_in
//   sample_in      in   16-bit signed sample from the NCO
//   mute           in   sampled at frame load; forces a zero word
//   bclk           out  I2S bit clock
//   lrclk          out  word select (0 = left, 1 = right)
//   sdata          out  serial data, MSB first, one BCLK after each LRCLK edge
//   underrun       out  one-cycle pulse: frame loaded without a fresh sample
//   overrun        out  one-cycle pulse: held sample overwritten before load
module i2s_transmitter #(
  parameter int BCLK_HALF = 2,
  parameter int SLOT_BITS = 32
) (
  input  logic        master_clk,
  input  logic        rst,
  input  logic        sample_clk_en,
  input  logic [15:0] sample_in,
  input  logic        mute,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        overrun
);

  localparam int DW         = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] MSB_POS  = BW'(16);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   tx_word_q, tx_word_d;
  logic          fresh_q, fresh_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;

  logic          div_wrap;
  logic          fall_ev;
  logic          frame_load;
  logic [BW-1:0] bit_cnt_nxt;
  logic [BW-1:0] slot_pos;
  logic [BW-1:0] bit_idx;

  always_comb begin
    div_wrap    = (div_cnt_q == DIV_LAST);
    fall_ev     = div_wrap & bclk_q;
    // The load coincides with the fall event that wraps the bit counter.
    frame_load  = fall_ev & (bit_cnt_q == BIT_LAST);
    bit_cnt_nxt = frame_load ? '0 : bit_cnt_q + 1'b1;
    slot_pos    = (bit_cnt_nxt >= SLOT_W) ? bit_cnt_nxt - SLOT_W : bit_cnt_nxt;
    // Slot position 1 carries bit 15, position 16 carries bit 0.
    bit_idx     = MSB_POS - slot_pos;
  end

  always_comb begin
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d     = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    tx_word_d  = tx_word_q;
    hold_d     = hold_q;
    fresh_d    = fresh_q;

    if (fall_ev) begin
      bit_cnt_d = bit_cnt_nxt;
      lrclk_d   = (bit_cnt_nxt >= SLOT_W);
      sdata_d   = ((slot_pos != '0) && (slot_pos <= MSB_POS)) ? tx_word_q[bit_idx[3:0]] : 1'b0;
    end

    // Load first, then capture: on a collision the load takes the old
    // hold value and the new sample is left fresh for the next frame.
    if (frame_load) begin
      tx_word_d = mute ? 16'h0000 : hold_q;
      fresh_d   = 1'b0;
    end
    if (sample_clk_en) begin
      hold_d  = sample_in;
      fresh_d = 1'b1;
    end

    underrun_d = frame_load & ~fresh_q;
    overrun_d  = sample_clk_en & fresh_q & ~frame_load;
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      hold_q     <= 16'h0000;
      tx_word_q  <= 16'h0000;
      fresh_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      hold_q     <= hold_d;
      tx_word_q  <= tx_word_d;
      fresh_q    <= fresh_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Purpose: scoreboard bench for i2s_transmitter; a monitor decodes whole frames from bclk/lrclk/sdata.
// Latency: expected frame words are queued with their frame index and popped when that frame completes.
// Backpressure: none; the bench drives the strobe freely and counts pulse outputs per frame window.
module tb_i2s_transmitter;

  logic        master_clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_clk_en = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        mute = 1'b0;
  logic        bclk, lrclk, sdata, underrun, overrun;

  always #5 master_clk = ~master_clk;

  i2s_transmitter #(.BCLK_HALF(2), .SLOT_BITS(32)) dut (
    .master_clk    (master_clk),
    .rst           (rst),
    .sample_clk_en (sample_clk_en),
    .sample_in     (sample_in),
    .mute          (mute),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun),
    .overrun       (overrun)
  );

  typedef struct {
    int          frame;
    logic [15:0] word;
    int          ur;
    int          ov;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;

  int          fall_cnt = 0;
  int          nrise = 0;
  int          ur_cnt = 0;
  int          ov_cnt = 0;
  logic        prev_bclk = 1'b0;
  logic [63:0] mon_bits = '0;
  logic [63:0] mon_lr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  task automatic expect_frame(input int k, input logic [15:0] w, input int u, input int o);
    exp_t e;
    e.frame = k;
    e.word  = w;
    e.ur    = u;
    e.ov    = o;
    sb.push_back(e);
  endtask

  // Compare one completed frame against the head of the scoreboard.
  task automatic finalize(input int k);
    exp_t        e;
    logic [63:0] ed;
    logic [63:0] el;
    int          b;
    if (sb.size() == 0) return;
    if (sb[0].frame != k) return;
    e = sb.pop_front();
    for (int q = 0; q < 64; q++) begin
      b     = q % 32;
      ed[q] = (b >= 1 && b <= 16) ? e.word[16 - b] : 1'b0;
      el[q] = (q >= 32);
    end
    chk($sformatf("frame%0d_sdata", k), mon_bits, ed);
    chk($sformatf("frame%0d_lrclk", k), mon_lr, el);
    chk($sformatf("frame%0d_bclk_rises", k), nrise, 64);
    chk($sformatf("frame%0d_underrun", k), ur_cnt, e.ur);
    chk($sformatf("frame%0d_overrun", k), ov_cnt, e.ov);
  endtask

  // Monitor: sample away from the active edge, count bclk falls, collect
  // one bit per bclk rise, close a frame every 64 falls.
  initial begin
    int p;
    forever begin
      @(negedge master_clk);
      if (!rst) begin
        fall_cnt  = 0;
        prev_bclk = 1'b0;
        nrise     = 0;
        ur_cnt    = 0;
        ov_cnt    = 0;
      end else begin
        if (prev_bclk && !bclk) begin
          fall_cnt++;
          if (fall_cnt % 64 == 0) begin
            finalize(fall_cnt / 64 - 1);
            nrise  = 0;
            ur_cnt = 0;
            ov_cnt = 0;
          end
        end
        if (!prev_bclk && bclk) begin
          p           = fall_cnt % 64;
          mon_bits[p] = sdata;
          mon_lr[p]   = lrclk;
          nrise++;
        end
        if (underrun === 1'b1) ur_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        prev_bclk = bclk;
      end
    end
  end

  task automatic wait_fall(input int n);
    int guard = 0;
    while (fall_cnt < n && guard < 5000) begin
      @(negedge master_clk);
      guard++;
    end
    if (fall_cnt < n) begin
      chk("wait_fall_timeout", fall_cnt, n);
      finish_up();
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge master_clk);
    sample_in     = v;
    sample_clk_en = 1'b1;
    @(negedge master_clk);
    sample_clk_en = 1'b0;
  endtask

  task automatic release_and_time();
    int   t1 = -1;
    int   t2 = -1;
    logic pv = 1'b0;
    @(negedge master_clk);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge master_clk);
      #1;
      if (bclk && !pv) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      pv = bclk;
    end
    chk("first_bclk_rise_cycle", t1, 2);
    chk("bclk_period", t2 - t1, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_chk++;
    finish_up();
  end

  initial begin
    rst = 1'b0;
    repeat (10) @(posedge master_clk);
    #1;
    chk("reset_outputs", {bclk, lrclk, sdata, underrun, overrun}, 5'b00000);
    release_and_time();

    expect_frame(0, 16'h0000, 0, 0);
    expect_frame(1, 16'hA5C3, 0, 0);
    wait_fall(10);   strobe(16'hA5C3);

    expect_frame(2, 16'h8000, 0, 0);
    wait_fall(74);   strobe(16'h8000);

    // One capture, then two starved loads repeating the held word.
    expect_frame(3, 16'h1234, 0, 0);
    expect_frame(4, 16'h1234, 1, 0);
    expect_frame(5, 16'h1234, 1, 1);
    wait_fall(138);  strobe(16'h1234);

    // Two strobes inside frame 5: overrun once, newest wins.
    expect_frame(6, 16'h2222, 0, 0);
    wait_fall(330);  strobe(16'h1111);
    wait_fall(350);  strobe(16'h2222);

    // Strobe aligned with the frame-7 load cycle (fall 448).
    expect_frame(7, 16'h3333, 0, 0);
    expect_frame(8, 16'h4444, 0, 0);
    wait_fall(394);  strobe(16'h3333);
    wait_fall(446);
    @(negedge bclk);
    repeat (3) @(posedge master_clk);
    @(negedge master_clk);
    sample_in     = 16'h4444;
    sample_clk_en = 1'b1;
    @(negedge master_clk);
    sample_clk_en = 1'b0;

    // Mute held across the frame-9 load.
    expect_frame(9, 16'h0000, 0, 0);
    wait_fall(520);  mute = 1'b1;
    wait_fall(522);  strobe(16'h7FFF);
    wait_fall(600);  mute = 1'b0;

    // Reset during frame 10 at bit 20 while bclk is high.
    wait_fall(660);
    @(posedge bclk);
    @(negedge master_clk);
    rst = 1'b0;
    #1;
    chk("midframe_reset_pins", {bclk, lrclk, sdata}, 3'b000);
    repeat (5) @(posedge master_clk);

    expect_frame(0, 16'h0000, 0, 0);
    expect_frame(1, 16'h0000, 1, 0);
    release_and_time();
    expect_frame(2, 16'hABCD, 0, 0);
    wait_fall(74);   strobe(16'hABCD);

    wait_fall(193);
    repeat (4) @(negedge master_clk);
    chk("scoreboard_drained", sb.size(), 0);
    finish_up();
  end

endmodule
